// File: rtl/point_mean_accum.sv
// Per-frame 3-D point accumulator. At frame end it computes per-axis means through a shared serial divider.
// Optional build macro MEAN_ROUND_EN biases each dividend by count/2 so the means round to nearest.
module point_mean_accum #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16,
    parameter int SUM_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pt_valid,
    input  logic [DATA_W-1:0] i_pt_x,
    input  logic [DATA_W-1:0] i_pt_y,
    input  logic [DATA_W-1:0] i_pt_z,
    input  logic              i_frame_end,
    output logic              o_div_valid,
    output logic [SUM_W-1:0]  o_div_dend,
    output logic [SUM_W-1:0]  o_div_dsor,
    input  logic              i_div_valid,
    input  logic [SUM_W-1:0]  i_div_quot,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_mean_x,
    output logic [DATA_W-1:0] o_mean_y,
    output logic [DATA_W-1:0] o_mean_z,
    output logic [CNT_W-1:0]  o_cnt,
    output logic              o_empty,
    output logic              o_ovf,
    output logic              o_busy
);

    typedef enum logic [1:0] {ACC, REQ, WAIT, OUT} state_t;

    state_t             state_q, state_d;
    logic [1:0]         axis_q, axis_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [SUM_W-1:0]   sum_q [3];
    logic [SUM_W-1:0]   sum_d [3];
    logic [DATA_W-1:0]  mean_x_q, mean_x_d, mean_y_q, mean_y_d;
    logic [DATA_W-1:0]  out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;
    logic [CNT_W-1:0]   cnt_out_q, cnt_out_d;

    logic [DATA_W-1:0]  pt [3];
    logic [SUM_W:0]     add_r [3];
    logic [SUM_W-1:0]   sel_sum;
    logic [DATA_W-1:0]  quot_mean;

    assign pt[0] = i_pt_x;
    assign pt[1] = i_pt_y;
    assign pt[2] = i_pt_z;

    // A quotient wider than DATA_W cannot arise from a true mean; clamp instead of wrapping.
    assign quot_mean = (|i_div_quot[SUM_W-1:DATA_W]) ? {DATA_W{1'b1}} : i_div_quot[DATA_W-1:0];

    always_comb begin
        for (int a = 0; a < 3; a++) begin
            add_r[a] = {1'b0, sum_q[a]} + {1'b0, {(SUM_W-DATA_W){1'b0}}, pt[a]};
        end
    end

    always_comb begin
        case (axis_q)
            2'd0:    sel_sum = sum_q[0];
            2'd1:    sel_sum = sum_q[1];
            default: sel_sum = sum_q[2];
        endcase
    end

`ifdef MEAN_ROUND_EN
    function automatic logic [SUM_W-1:0] sat_sum(input logic [SUM_W-1:0] a,
                                                 input logic [SUM_W-1:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
    endfunction

    logic [SUM_W-1:0] dend_val;
    assign dend_val = sat_sum(sel_sum, {{(SUM_W-CNT_W){1'b0}}, (count_q >> 1)});
`else
    logic [SUM_W-1:0] dend_val;
    assign dend_val = sel_sum;
`endif

    always_comb begin
        o_div_valid = (state_q == REQ);
        o_div_dend  = '0;
        o_div_dsor  = '0;
        if (state_q == REQ) begin
            o_div_dend = dend_val;
            o_div_dsor = {{(SUM_W-CNT_W){1'b0}}, count_q};
        end
    end

    always_comb begin
        state_d   = state_q;
        axis_d    = axis_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        mean_x_d  = mean_x_q;
        mean_y_d  = mean_y_q;
        out_x_d   = out_x_q;
        out_y_d   = out_y_q;
        out_z_d   = out_z_q;
        cnt_out_d = cnt_out_q;
        for (int a = 0; a < 3; a++) begin
            sum_d[a] = sum_q[a];
        end

        case (state_q)
            ACC: begin
                if (i_pt_valid) begin
                    // A sample at saturated count is dropped entirely so sums stay consistent with count.
                    if (count_q == {CNT_W{1'b1}}) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                        for (int a = 0; a < 3; a++) begin
                            if (add_r[a][SUM_W]) begin
                                sum_d[a] = {SUM_W{1'b1}};
                                ovf_d    = 1'b1;
                            end else begin
                                sum_d[a] = add_r[a][SUM_W-1:0];
                            end
                        end
                    end
                end
                if (i_frame_end) begin
                    axis_d = 2'd0;
                    if (count_d == '0) begin
                        state_d   = OUT;
                        out_x_d   = '0;
                        out_y_d   = '0;
                        out_z_d   = '0;
                        cnt_out_d = '0;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (i_div_valid) begin
                    case (axis_q)
                        2'd0: begin
                            mean_x_d = quot_mean;
                            axis_d   = 2'd1;
                            state_d  = REQ;
                        end
                        2'd1: begin
                            mean_y_d = quot_mean;
                            axis_d   = 2'd2;
                            state_d  = REQ;
                        end
                        default: begin
                            out_x_d   = mean_x_q;
                            out_y_d   = mean_y_q;
                            out_z_d   = quot_mean;
                            cnt_out_d = count_q;
                            state_d   = OUT;
                        end
                    endcase
                end
            end
            default: begin
                for (int a = 0; a < 3; a++) begin
                    sum_d[a] = '0;
                end
                count_d = '0;
                ovf_d   = 1'b0;
                state_d = ACC;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ACC;
            axis_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            mean_x_q  <= '0;
            mean_y_q  <= '0;
            out_x_q   <= '0;
            out_y_q   <= '0;
            out_z_q   <= '0;
            cnt_out_q <= '0;
            for (int a = 0; a < 3; a++) begin
                sum_q[a] <= '0;
            end
        end else begin
            state_q   <= state_d;
            axis_q    <= axis_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            mean_x_q  <= mean_x_d;
            mean_y_q  <= mean_y_d;
            out_x_q   <= out_x_d;
            out_y_q   <= out_y_d;
            out_z_q   <= out_z_d;
            cnt_out_q <= cnt_out_d;
            for (int a = 0; a < 3; a++) begin
                sum_q[a] <= sum_d[a];
            end
        end
    end

    assign o_valid  = (state_q == OUT);
    assign o_empty  = (state_q == OUT) && (count_q == '0);
    assign o_ovf    = (state_q == OUT) && ovf_q;
    assign o_busy   = (state_q != ACC);
    assign o_mean_x = out_x_q;
    assign o_mean_y = out_y_q;
    assign o_mean_z = out_z_q;
    assign o_cnt    = cnt_out_q;

endmodule

// File: tb/tb_point_mean_accum.sv
// Scoreboard bench for point_mean_accum with a behavioral fixed-latency divider model.
// Expected results are queued at frame end and checked by an independent monitor.
module tb_point_mean_accum;

    localparam int DATA_W  = 16;
    localparam int CNT_W   = 16;
    localparam int SUM_W   = 32;
    localparam int DIV_LAT = SUM_W + 1;
    localparam int LAT     = 3*DIV_LAT + 4;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_pt_valid;
    logic [DATA_W-1:0] i_pt_x, i_pt_y, i_pt_z;
    logic              i_frame_end;
    logic              o_div_valid;
    logic [SUM_W-1:0]  o_div_dend, o_div_dsor;
    logic              i_div_valid;
    logic [SUM_W-1:0]  i_div_quot;
    logic              o_valid;
    logic [DATA_W-1:0] o_mean_x, o_mean_y, o_mean_z;
    logic [CNT_W-1:0]  o_cnt;
    logic              o_empty, o_ovf, o_busy;

    point_mean_accum #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_pt_valid(i_pt_valid), .i_pt_x(i_pt_x), .i_pt_y(i_pt_y), .i_pt_z(i_pt_z),
        .i_frame_end(i_frame_end),
        .o_div_valid(o_div_valid), .o_div_dend(o_div_dend), .o_div_dsor(o_div_dsor),
        .i_div_valid(i_div_valid), .i_div_quot(i_div_quot),
        .o_valid(o_valid), .o_mean_x(o_mean_x), .o_mean_y(o_mean_y), .o_mean_z(o_mean_z),
        .o_cnt(o_cnt), .o_empty(o_empty), .o_ovf(o_ovf), .o_busy(o_busy)
    );

    typedef struct {
        int          mx, my, mz, cnt, empty, ovf;
        int unsigned at_cyc;
    } exp_t;

    exp_t        sb [$];
    int          n_vec = 0;
    int          n_fail = 0;
    int          div_reqs = 0;
    int unsigned cyc = 0;
    int unsigned fe_cyc = 0;

    logic              div_pend = 1'b0;
    int unsigned       div_fire = 0;
    logic [SUM_W-1:0]  div_q = '0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic applyStimulus(input logic pv, input int x, input int y, input int z, input logic fe);
        @(negedge i_clk);
        i_pt_valid  = pv;
        i_pt_x      = DATA_W'(x);
        i_pt_y      = DATA_W'(y);
        i_pt_z      = DATA_W'(z);
        i_frame_end = fe;
        if (fe) fe_cyc = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic expectResult(input int mx, input int my, input int mz, input int cnt,
                                input int empty, input int ovf, input int lat);
        exp_t e;
        e.mx = mx; e.my = my; e.mz = mz; e.cnt = cnt;
        e.empty = empty; e.ovf = ovf; e.at_cyc = fe_cyc + lat;
        sb.push_back(e);
    endtask

    // External divider: one request outstanding, answers DIV_LAT cycles later, ignores reset.
    always @(negedge i_clk) begin
        if (div_pend && cyc == div_fire) begin
            i_div_valid = 1'b1;
            i_div_quot  = div_q;
            div_pend    = 1'b0;
        end else begin
            i_div_valid = 1'b0;
            i_div_quot  = '0;
        end
        if (o_div_valid) begin
            div_reqs++;
            div_pend = 1'b1;
            div_fire = cyc + DIV_LAT;
            div_q    = (o_div_dsor == '0) ? '1 : o_div_dend / o_div_dsor;
        end
    end

    // Monitor: protocol checks every cycle and scoreboard compare on each result pulse.
    always @(negedge i_clk) begin
        exp_t e;
        if (!o_div_valid) begin
            checkOutput("dend_idle_zero", int'(o_div_dend), 0);
            checkOutput("dsor_idle_zero", int'(o_div_dsor), 0);
        end
        if (!o_valid) begin
            checkOutput("empty_outside_out", int'(o_empty), 0);
            checkOutput("ovf_outside_out", int'(o_ovf), 0);
        end else if (sb.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL unexpected_valid: got o_valid=1 at cycle %0d, expected none", cyc);
        end else begin
            e = sb.pop_front();
            checkOutput("valid_cycle", int'(cyc), int'(e.at_cyc));
            checkOutput("mean_x", int'(o_mean_x), e.mx);
            checkOutput("mean_y", int'(o_mean_y), e.my);
            checkOutput("mean_z", int'(o_mean_z), e.mz);
            checkOutput("cnt", int'(o_cnt), e.cnt);
            checkOutput("empty", int'(o_empty), e.empty);
            checkOutput("ovf", int'(o_ovf), e.ovf);
        end
    end

    initial begin
        int reqs0;
        i_rst_n = 1'b0;
        i_pt_valid = 1'b0; i_pt_x = '0; i_pt_y = '0; i_pt_z = '0; i_frame_end = 1'b0;
        i_div_valid = 1'b0; i_div_quot = '0;
        repeat (3) @(negedge i_clk);
        checkOutput("rst_valid", int'(o_valid), 0);
        checkOutput("rst_busy", int'(o_busy), 0);
        checkOutput("rst_div_valid", int'(o_div_valid), 0);
        checkOutput("rst_mean_x", int'(o_mean_x), 0);
        checkOutput("rst_cnt", int'(o_cnt), 0);
        i_rst_n = 1'b1;
        idle(2);

        $display("[TB] two-sample frame");
        applyStimulus(1'b1, 10, 20, 30, 1'b0);
        applyStimulus(1'b1, 11, 21, 33, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
`ifdef MEAN_ROUND_EN
        expectResult(11, 21, 32, 2, 0, 0, LAT);
`else
        expectResult(10, 20, 31, 2, 0, 0, LAT);
`endif
        idle(5);
        checkOutput("busy_mid_frame", int'(o_busy), 1);
        idle(LAT);

        $display("[TB] empty frame");
        reqs0 = div_reqs;
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        expectResult(0, 0, 0, 0, 1, 0, 1);
        idle(5);
        checkOutput("empty_no_div_req", div_reqs - reqs0, 0);

        $display("[TB] sample with frame_end");
        applyStimulus(1'b1, 1, 2, 3, 1'b0);
        applyStimulus(1'b1, 7, 8, 9, 1'b1);
        expectResult(4, 5, 6, 2, 0, 0, LAT);
        idle(LAT + 5);

        $display("[TB] inputs while busy");
        applyStimulus(1'b1, 100, 100, 100, 1'b0);
        applyStimulus(1'b1, 200, 200, 200, 1'b1);
        expectResult(150, 150, 150, 2, 0, 0, LAT);
        for (int i = 0; i < 90; i++) applyStimulus(1'b1, 999, 999, 999, (i % 7) == 0);
        idle(LAT - 90 + 5);
        applyStimulus(1'b1, 3, 6, 9, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        expectResult(3, 6, 9, 1, 0, 0, LAT);
        idle(LAT + 5);

        $display("[TB] count saturation");
        for (int i = 0; i < 65536; i++) applyStimulus(1'b1, 65535, 65535, 65535, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        expectResult(65535, 65535, 65535, 65535, 0, 1, LAT);
        idle(LAT + 5);

        $display("[TB] reset during divide");
        applyStimulus(1'b1, 40, 40, 40, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        idle(10);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        i_pt_valid = 1'b0;
        i_frame_end = 1'b0;
        #1;
        checkOutput("midrst_busy", int'(o_busy), 0);
        checkOutput("midrst_div_valid", int'(o_div_valid), 0);
        checkOutput("midrst_mean_x", int'(o_mean_x), 0);
        checkOutput("midrst_mean_z", int'(o_mean_z), 0);
        checkOutput("midrst_cnt", int'(o_cnt), 0);
        idle(2);
        i_rst_n = 1'b1;
        idle(40);
        checkOutput("post_late_div_busy", int'(o_busy), 0);
        applyStimulus(1'b1, 5, 5, 5, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        expectResult(5, 5, 5, 1, 0, 0, LAT);
        idle(LAT + 5);

        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/point_mean_accum.md
# point_mean_accum

Accumulates a frame's worth of unsigned 3-D point samples (x, y, z) and sample count. At frame end it computes the per-axis mean by issuing three serialized requests to the shared sequential unsigned divider. The block sits directly upstream of the divider, drives its request port, consumes its quotient, and presents the mean vector downstream as a one-cycle result pulse.

## Interface
Parameters:
- DATA_W, 16, width of each coordinate and of each mean output
- CNT_W, 16, width of sample counter; must be < SUM_W
- SUM_W, 32, accumulator width; equals divider dividend/divisor width

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_pt_valid  in  1  sample strobe
- i_pt_x / i_pt_y / i_pt_z  in  DATA_W each  sample coordinates
- i_frame_end  in  1  end-of-frame strobe
- o_div_valid  out  1  one-cycle divide request
- o_div_dend  out  SUM_W  dividend (axis sum, optionally rounded)
- o_div_dsor  out  SUM_W  divisor (count, zero-extended)
- i_div_valid  in  1  divider result strobe
- i_div_quot  in  SUM_W  divider quotient
- o_valid  out  1  one-cycle result pulse
- o_mean_x / o_mean_y / o_mean_z  out  DATA_W each  means, valid with o_valid
- o_cnt  out  CNT_W  sample count of the frame, valid with o_valid
- o_empty  out  1  frame had zero samples, valid with o_valid
- o_ovf  out  1  sum or count saturated this frame, valid with o_valid
- o_busy  out  1  high in every state except ACC

## Operation
- States: ACC, REQ, WAIT, OUT. Reset enters ACC. Sums, count, means, axis index, and all outputs are 0 at reset.
- ACC:
  - i_pt_valid adds each coordinate to its SUM_W sum and increments count.
  - Sums saturate at 2^SUM_W-1. Count saturates at 2^CNT_W-1; a sample arriving at saturated count is dropped entirely. Either event sets the sticky ovf flag.
  - i_frame_end moves to REQ with axis index 0, or to OUT if count is 0. A sample in the same cycle as i_frame_end is included.
- REQ:
  - o_div_valid = 1 for exactly one cycle.
  - o_div_dend = sum[axis], o_div_dsor = count.
  - Go to WAIT.
- WAIT:
  - On i_div_valid, capture i_div_quot[DATA_W-1:0] into mean[axis].
  - If axis < 2: increment axis, go to REQ. Otherwise go to OUT.
  - i_div_valid outside WAIT is ignored.
- OUT:
  - o_valid = 1 for one cycle; means, o_cnt, o_empty, o_ovf are driven.
  - On a zero-count frame, means are 0 and o_empty = 1.
  - Sums, count, and ovf clear. Go to ACC.
- Outside ACC, i_pt_valid and i_frame_end are ignored (o_busy = 1). Upstream must hold off.
- o_div_dend and o_div_dsor are 0 whenever o_div_valid = 0.
- Means and o_cnt hold their last values until the next OUT. o_empty and o_ovf are 0 outside OUT.
- Mid-operation reset: returns to ACC immediately, the in-flight divide is abandoned, and all state clears.

## Timing
- Cycle 0 = i_frame_end sampled in ACC.
- o_div_valid fires at cycles 1, D+2, 2D+3, where D = divider latency from request to i_div_valid (D = SUM_W+1 = 33 at defaults).
- o_valid fires at cycle 3D+4 (103 at defaults).
- Zero-count frame: o_valid at cycle 1.
- First sample accepted at cycle (o_valid cycle)+1.
- Only one divide is outstanding at any time, because the divider has no ready signal.

## Configuration
- MEAN_ROUND_EN defined: o_div_dend = sum[axis] + (count>>1), saturating at 2^SUM_W-1, giving round-to-nearest means.
- MEAN_ROUND_EN undefined: o_div_dend = sum[axis], giving truncated means.
- Latency is identical in both builds.

## Test plan
- Two samples (10,20,30), (11,21,33), then frame_end: means (10,20,31), cnt 2 without MEAN_ROUND_EN; (11,21,32) with it. o_valid at cycle 103.
- frame_end with no samples: o_valid at cycle 1, o_empty = 1, means 0, no o_div_valid pulse.
- Sample (7,8,9) in the same cycle as frame_end, following sample (1,2,3): means (4,5,6), cnt 2.
- Samples and frame_end driven while o_busy = 1: ignored. The next frame's result reflects only samples accepted in ACC.
- 65535 samples of (65535,65535,65535), then one more sample, then frame_end: o_ovf = 1, cnt 65535, means 65535.
- Reset asserted while in WAIT: all outputs 0, state ACC. A following late i_div_valid is ignored. The next frame of (5,5,5) yields (5,5,5).
